thread_sched_rr: RTL

Parametrised round-robin thread scheduler for the multi-CPU core. It replaces the single-slot pending/stop register scheme with a pending FIFO of configurable depth and an active thread table with configurable size. STOP removes an entry in one cycle through a parallel address match. It sits between the CPU command path (RUN/STOP requests) and the dispatch logic, which pulls the next thread to execute.

---
 rtl/thread_sched_pkg.sv | 22 ++
 rtl/thread_pend_fifo.sv | 51 +++++
 rtl/thread_sched_rr.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/thread_sched_pkg.sv
// Shared definitions for the round-robin thread scheduler: command codes,
// default widths and the pending/active entry layout.
package thread_sched_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int ADDR_W_DEF     = 32;
    localparam int THREADS_DEF    = 8;
    localparam int PEND_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        THR_OP_NOP  = 2'd0,
        THR_OP_RUN  = 2'd1,
        THR_OP_STOP = 2'd2,
        THR_OP_RSVD = 2'd3
    } thr_op_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] addr;
    } thr_entry_t;

endpackage

// File: rtl/thread_pend_fifo.sv
// Synchronous FIFO holding threads admitted by RUN but not yet promoted.
// Same-cycle push and pop are legal; pointers wrap modulo DEPTH.
module thread_pend_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/thread_sched_rr.sv
// Round-robin thread scheduler: RUN admits into a pending FIFO, next_req
// promotes pending threads into the active table or rotates over it.
// Commands and requests are single-cycle strobes with no back-pressure; each
// is answered by a one-cycle pulse (cmd_done / next_valid) in the next cycle.
module thread_sched_rr
    import thread_sched_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int THREADS    = THREADS_DEF,
    parameter int PEND_DEPTH = PEND_DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              cmd_valid,
    input  logic [1:0]                        cmd_op,
    input  logic [DATA_W-1:0]                 cmd_data,
    input  logic [ADDR_W-1:0]                 cmd_addr,
    output logic                              cmd_done,
    output logic                              cmd_ok,
    input  logic                              next_req,
    output logic                              next_valid,
    output logic [ADDR_W-1:0]                 next_addr,
    output logic [DATA_W-1:0]                 next_data,
    output logic [$clog2(THREADS+1)-1:0]      active_cnt,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   pend_cnt,
    output logic                              full
);

    localparam int IDX_W  = $clog2(THREADS);
    localparam int CNT_W  = $clog2(THREADS+1);
    localparam int PCNT_W = $clog2(PEND_DEPTH+1);
    localparam int ENT_W  = DATA_W + ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    logic [ADDR_W-1:0] act_addr [THREADS];
    logic [DATA_W-1:0] act_data [THREADS];
    logic [IDX_W-1:0]  rr_idx;

    logic [ADDR_W-1:0] addr_n [THREADS];
    logic [DATA_W-1:0] data_n [THREADS];
    logic [CNT_W-1:0]  cnt_s, cnt_n;
    logic [IDX_W-1:0]  rr_s, rr_n, match_idx, last_idx;
    logic              match_hit;
    logic              is_run, is_stop, run_ok, stop_hit, promote, rotate, full_n;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    int                pend_next;

    assign is_run   = en && cmd_valid && (cmd_op == THR_OP_RUN);
    assign is_stop  = en && cmd_valid && (cmd_op == THR_OP_STOP);
    assign run_ok   = is_run && (pend_cnt < PCNT_W'(PEND_DEPTH)) && !full;
    assign stop_hit = is_stop && match_hit;
    assign last_idx = IDX_W'(active_cnt - CNT_ONE);

    thread_pend_fifo #(
        .W     (ENT_W),
        .DEPTH (PEND_DEPTH)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (run_ok),
        .pop   (promote),
        .din   ({cmd_data, cmd_addr}),
        .head  (head),
        .count (pend_cnt)
    );

    // Descending scan so the lowest matching valid index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < active_cnt) && (act_addr[i] == cmd_addr)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // STOP removal first, then dispatch selection on the post-removal table.
    always_comb begin
        for (int i = 0; i < THREADS; i++) begin
            addr_n[i] = act_addr[i];
            data_n[i] = act_data[i];
        end
        if (stop_hit) begin
            addr_n[match_idx] = act_addr[last_idx];
            data_n[match_idx] = act_data[last_idx];
        end
        cnt_s   = active_cnt - CNT_W'(stop_hit);
        rr_s    = (stop_hit && (CNT_W'(rr_idx) >= cnt_s)) ? '0 : rr_idx;
        promote = en && next_req && (pend_cnt != '0) && (cnt_s < CNT_W'(THREADS));
        rotate  = en && next_req && !promote && (cnt_s != '0);
        cnt_n   = cnt_s;
        rr_n    = rr_s;
        disp_addr = addr_n[rr_s];
        disp_data = data_n[rr_s];
        if (promote) begin
            addr_n[IDX_W'(cnt_s)] = head[ADDR_W-1:0];
            data_n[IDX_W'(cnt_s)] = head[ENT_W-1:ADDR_W];
            cnt_n     = cnt_s + CNT_ONE;
            disp_addr = head[ADDR_W-1:0];
            disp_data = head[ENT_W-1:ADDR_W];
        end else if (rotate) begin
            rr_n = ((CNT_W'(rr_s) + CNT_ONE) == cnt_s) ? '0 : rr_s + IDX_ONE;
        end
        pend_next = int'(pend_cnt) + int'(run_ok) - int'(promote);
        full_n    = (int'(cnt_n) + pend_next) == THREADS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_cnt <= '0;
            rr_idx     <= '0;
            cmd_done   <= 1'b0;
            cmd_ok     <= 1'b0;
            next_valid <= 1'b0;
            next_addr  <= '0;
            next_data  <= '0;
            full       <= 1'b0;
        end else if (en) begin
            active_cnt <= cnt_n;
            rr_idx     <= rr_n;
            cmd_done   <= is_run || is_stop;
            cmd_ok     <= run_ok || stop_hit;
            next_valid <= promote || rotate;
            if (promote || rotate) begin
                next_addr <= disp_addr;
                next_data <= disp_data;
            end
            full <= full_n;
        end else begin
            cmd_done   <= 1'b0;
            cmd_ok     <= 1'b0;
            next_valid <= 1'b0;
        end
    end

    // Table contents are don't-care after reset; only active_cnt qualifies them.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            for (int i = 0; i < THREADS; i++) begin
                act_addr[i] <= addr_n[i];
                act_data[i] <= data_n[i];
            end
        end
    end

endmodule
